// File: rtl/regfile_wb_pkg.sv
// Package for the register-file write-back front end.
// Holds the shared constants and the types carried on the write-back
// buses: register address, data word and the buffered result entry.
// Optional feature macro used by the top level: REGFILE_WB_BYPASS_EN.
package regfile_wb_pkg;

  localparam int WIDTH          = 32;
  localparam int N_REGS         = 32;
  localparam int ADRS_W         = 5;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [ADRS_W-1:0] adrs_t;
  typedef logic [WIDTH-1:0]  word_t;

  // One buffered long-latency result: destination register plus value.
  typedef struct packed {
    adrs_t adrs;
    word_t data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Write-back bus bundle between the result producers, the write-back
// front end and the register file write port.
//   alu_valid/alu_adrs/alu_data : single-cycle ALU result, no backpressure
//   lsu_valid/lsu_ready/lsu_adrs/lsu_data : long-latency result handshake
//   wr_en/wr_adrs/wr_data : register file write port (registered)
//
// Handshake: an LSU result transfers on a rising clock edge where
// lsu_valid && lsu_ready. lsu_ready is a function of buffer state only and
// never looks at lsu_valid. While lsu_valid is high and the transfer has
// not happened, the producer holds lsu_adrs/lsu_data stable. The ALU path
// has no ready: every alu_valid cycle is consumed.
//
// Modports: master = producer/observer side, slave = write-back front end.
interface regfile_writeback_if;
  import regfile_wb_pkg::*;

  logic  alu_valid;
  adrs_t alu_adrs;
  word_t alu_data;

  logic  lsu_valid;
  logic  lsu_ready;
  adrs_t lsu_adrs;
  word_t lsu_data;

  logic  wr_en;
  adrs_t wr_adrs;
  word_t wr_data;

  modport master (
    output alu_valid, alu_adrs, alu_data,
    output lsu_valid, lsu_adrs, lsu_data,
    input  lsu_ready,
    input  wr_en, wr_adrs, wr_data
  );

  modport slave (
    input  alu_valid, alu_adrs, alu_data,
    input  lsu_valid, lsu_adrs, lsu_data,
    output lsu_ready,
    output wr_en, wr_adrs, wr_data
  );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t used to buffer long-latency
// results until the register file write port is free.
// Ports:
//   clk_cpu, reset_n : clock, asynchronous active-low reset
//   push, push_entry : write request and entry (ignored when full)
//   pop              : read request (ignored when empty); head advances
//   head             : entry at the read pointer (valid when !empty)
//   full, empty      : occupancy flags
//   count            : occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk_cpu,
  input  logic                     reset_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_wr;
  logic             do_rd;
  wb_entry_t        mem [DEPTH];

  assign do_wr = push && !full;
  assign do_rd = pop && !empty;

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says so.
  always_ff @(posedge clk_cpu) begin
    if (do_wr) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == (PTR_W+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end of the CPU register file and the
// only driver of its write port. ALU results go straight to the registered
// write port; long-latency (load/multiply) results are buffered in wb_fifo
// and drained whenever the ALU is not writing. A per-register pending
// scoreboard tells the issue stage which sources are still unresolved.
// Ports:
//   clk_cpu, reset_n        : clock, asynchronous active-low reset
//   bus (slave)             : ALU/LSU result inputs, lsu_ready, wr_* outputs
//   iss_claim/_adrs         : issue stage marks a destination as pending
//   chk_adrs_a/b, busy_a/b  : source check; busy means stall
//   sb_err                  : sticky, a claim hit an already-pending register
//   idle                    : buffer empty, nothing pending, no write presented
// Optional (REGFILE_WB_BYPASS_EN defined):
//   fwd_hit_a/b, fwd_data   : value on the write port matches a checked
//                             source; busy for that source is masked.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk_cpu,
  input  logic                reset_n,
  regfile_writeback_if.slave  bus,
  input  logic                iss_claim,
  input  adrs_t               iss_claim_adrs,
  input  adrs_t               chk_adrs_a,
  input  adrs_t               chk_adrs_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic                sb_err,
  output logic                idle
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                fwd_hit_a,
  output logic                fwd_hit_b,
  output word_t               fwd_data
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         lsu_entry;
  wb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              drain;

  logic [N_REGS-1:0] pending;
  logic [N_REGS-1:0] pend_set;
  logic [N_REGS-1:0] pend_clr;
  logic              claim_hit;
  logic              wr_from_lsu;

  assign lsu_entry     = '{adrs: bus.lsu_adrs, data: bus.lsu_data};
  assign bus.lsu_ready = !fifo_full;
  // The ALU always wins the write port; the buffer head waits for a gap.
  assign drain         = !bus.alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_cpu    (clk_cpu),
    .reset_n    (reset_n),
    .push       (bus.lsu_valid),
    .push_entry (lsu_entry),
    .pop        (drain),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Registered write port. Writes to register 0 still consume their slot
  // but never raise the strobe.
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_adrs <= '0;
      bus.wr_data <= '0;
      wr_from_lsu <= 1'b0;
    end else if (bus.alu_valid) begin
      bus.wr_en   <= (bus.alu_adrs != '0);
      bus.wr_adrs <= bus.alu_adrs;
      bus.wr_data <= bus.alu_data;
      wr_from_lsu <= 1'b0;
    end else if (drain) begin
      bus.wr_en   <= (head.adrs != '0);
      bus.wr_adrs <= head.adrs;
      bus.wr_data <= head.data;
      wr_from_lsu <= 1'b1;
    end else begin
      bus.wr_en   <= 1'b0;
      wr_from_lsu <= 1'b0;
    end
  end

  // A drained result clears its pending bit during the cycle its write is
  // on the port, so without bypass the source becomes free only once the
  // register file actually holds the value. ALU writes leave it alone.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (iss_claim) pend_set[iss_claim_adrs] = 1'b1;
    pend_set[0] = 1'b0;
    if (bus.wr_en && wr_from_lsu) pend_clr[bus.wr_adrs] = 1'b1;
  end

  assign claim_hit = iss_claim && (iss_claim_adrs != '0) && pending[iss_claim_adrs];

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      // Set after clear: a fresh claim beats a same-cycle completion.
      pending <= (pending & ~pend_clr) | pend_set;
      if (claim_hit) sb_err <= 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit_a = bus.wr_en && (bus.wr_adrs == chk_adrs_a) && (chk_adrs_a != '0);
  assign fwd_hit_b = bus.wr_en && (bus.wr_adrs == chk_adrs_b) && (chk_adrs_b != '0);
  assign fwd_data  = bus.wr_data;
  assign busy_a    = pending[chk_adrs_a] && (chk_adrs_a != '0) && !fwd_hit_a;
  assign busy_b    = pending[chk_adrs_b] && (chk_adrs_b != '0) && !fwd_hit_b;
`else
  assign busy_a    = pending[chk_adrs_a] && (chk_adrs_a != '0);
  assign busy_b    = pending[chk_adrs_b] && (chk_adrs_b != '0);
`endif

  assign idle = (fifo_count == '0) && (pending == '0) && !bus.wr_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback. A reference model of the write-port
// arbitration (ALU first, buffered LSU results in order) pushes every
// expected register write into exp_q as stimulus is applied; a monitor on
// the falling edge pops and compares each wr_en cycle. Directed sections
// cover reset, latency, scoreboard, full-buffer backpressure, register 0,
// sticky error plus mid-operation reset, and (with REGFILE_WB_BYPASS_EN)
// forwarding; a random section follows.
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  localparam int EW = $bits(wb_entry_t);

  logic  clk_cpu;
  logic  reset_n;
  logic  iss_claim;
  adrs_t iss_claim_adrs;
  adrs_t chk_adrs_a;
  adrs_t chk_adrs_b;
  logic  busy_a;
  logic  busy_b;
  logic  sb_err;
  logic  idle;
`ifdef REGFILE_WB_BYPASS_EN
  logic  fwd_hit_a;
  logic  fwd_hit_b;
  word_t fwd_data;
`endif

  regfile_writeback_if bus_if ();

  regfile_writeback dut (
    .clk_cpu        (clk_cpu),
    .reset_n        (reset_n),
    .bus            (bus_if),
    .iss_claim      (iss_claim),
    .iss_claim_adrs (iss_claim_adrs),
    .chk_adrs_a     (chk_adrs_a),
    .chk_adrs_b     (chk_adrs_b),
    .busy_a         (busy_a),
    .busy_b         (busy_b),
    .sb_err         (sb_err),
    .idle           (idle)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd_hit_a      (fwd_hit_a),
    .fwd_hit_b      (fwd_hit_b),
    .fwd_data       (fwd_data)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  // ---------------- scoreboard state ----------------
  int              total;
  int              bad;
  logic [EW-1:0]   exp_q[$];
  wb_entry_t       m_fifo[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every presented write must be the next expected one.
  always @(negedge clk_cpu) begin
    wb_entry_t e;
    if (reset_n && bus_if.wr_en) begin
      check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_adrs", 64'(bus_if.wr_adrs), 64'(e.adrs));
        check_eq("wr_data", 64'(bus_if.wr_data), 64'(e.data));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Applies the currently driven inputs for one clock, updating the model.
  task automatic step(output logic acc);
    wb_entry_t e;
    acc = 1'b0;
    if (reset_n) begin
      check_eq("lsu_ready", 64'(bus_if.lsu_ready), 64'(m_fifo.size() < FIFO_DEPTH_DEF));
      acc = bus_if.lsu_valid && (m_fifo.size() < FIFO_DEPTH_DEF);
      if (bus_if.alu_valid) begin
        if (bus_if.alu_adrs != '0) exp_q.push_back({bus_if.alu_adrs, bus_if.alu_data});
      end else if (m_fifo.size() != 0) begin
        e = m_fifo.pop_front();
        if (e.adrs != '0) exp_q.push_back(e);
      end
      if (acc) m_fifo.push_back('{adrs: bus_if.lsu_adrs, data: bus_if.lsu_data});
    end
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  task automatic drive_idle();
    bus_if.alu_valid = 1'b0;
    bus_if.alu_adrs  = '0;
    bus_if.alu_data  = '0;
    bus_if.lsu_valid = 1'b0;
    bus_if.lsu_adrs  = '0;
    bus_if.lsu_data  = '0;
    iss_claim        = 1'b0;
    iss_claim_adrs   = '0;
  endtask

  task automatic drive_alu(input logic v, input adrs_t a, input word_t d);
    bus_if.alu_valid = v;
    bus_if.alu_adrs  = a;
    bus_if.alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input adrs_t a, input word_t d);
    bus_if.lsu_valid = v;
    bus_if.lsu_adrs  = a;
    bus_if.lsu_data  = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drive_idle();
    chk_adrs_a = '0;
    chk_adrs_b = '0;
    repeat (2) @(posedge clk_cpu);
    #1;

    // Reset state
    check_eq("rst_wr_en",     64'(bus_if.wr_en),     64'd0);
    check_eq("rst_wr_adrs",   64'(bus_if.wr_adrs),   64'd0);
    check_eq("rst_wr_data",   64'(bus_if.wr_data),   64'd0);
    check_eq("rst_sb_err",    64'(sb_err),           64'd0);
    check_eq("rst_lsu_ready", 64'(bus_if.lsu_ready), 64'd1);
    check_eq("rst_idle",      64'(idle),             64'd1);
    reset_n = 1'b1;

    // 1: ALU write, one-cycle latency, then idle
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_eq("t1_wr_en",   64'(bus_if.wr_en),   64'd1);
    check_eq("t1_wr_adrs", 64'(bus_if.wr_adrs), 64'd5);
    check_eq("t1_wr_data", 64'(bus_if.wr_data), 64'hDEADBEEF);
    drive_alu(1'b0, '0, '0);
    tick();
    check_eq("t1_idle", 64'(idle), 64'd1);

    // 2: claim r7, LSU result two cycles later, busy until write lands
    chk_adrs_a     = 5'd7;
    iss_claim      = 1'b1;
    iss_claim_adrs = 5'd7;
    tick();
    iss_claim = 1'b0;
    check_eq("t2_busy_claimed", 64'(busy_a), 64'd1);
    check_eq("t2_not_idle", 64'(idle), 64'd0);
    tick();
    check_eq("t2_busy_wait", 64'(busy_a), 64'd1);
    drive_lsu(1'b1, 5'd7, 32'h1234);
    tick();
    drive_lsu(1'b0, '0, '0);
    check_eq("t2_busy_accepted", 64'(busy_a), 64'd1);
    check_eq("t2_no_wr_yet", 64'(bus_if.wr_en), 64'd0);
    tick();
    check_eq("t2_wr_en", 64'(bus_if.wr_en), 64'd1);
    check_eq("t2_wr_adrs", 64'(bus_if.wr_adrs), 64'd7);
`ifndef REGFILE_WB_BYPASS_EN
    check_eq("t2_busy_on_wr", 64'(busy_a), 64'd1);
`endif
    tick();
    check_eq("t2_busy_cleared", 64'(busy_a), 64'd0);

    // 3: fill the buffer under continuous ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_alu(1'b1, 5'(10 + i), 32'(32'hA000 + i));
      drive_lsu(1'b1, 5'(1 + i), $urandom());
      tick();
    end
    check_eq("t3_full_not_ready", 64'(bus_if.lsu_ready), 64'd0);
    drive_alu(1'b1, 5'd14, 32'hA004);
    drive_lsu(1'b1, 5'd5, 32'h5555);
    tick();
    check_eq("t3_still_full", 64'(bus_if.lsu_ready), 64'd0);
    drive_alu(1'b0, '0, '0);
    // Drain while full: r5 is still offered but cannot enter this cycle.
    tick();
    check_eq("t3_drain_r1", 64'(bus_if.wr_adrs), 64'd1);
    tick();
    drive_lsu(1'b0, '0, '0);
    check_eq("t3_drain_r2", 64'(bus_if.wr_adrs), 64'd2);
    tick();
    check_eq("t3_drain_r3", 64'(bus_if.wr_adrs), 64'd3);
    tick();
    check_eq("t3_drain_r4", 64'(bus_if.wr_adrs), 64'd4);
    tick();
    check_eq("t3_drain_r5", 64'(bus_if.wr_adrs), 64'd5);
    check_eq("t3_r5_data",  64'(bus_if.wr_data), 64'h5555);
    tick();
    check_eq("t3_done_idle", 64'(idle), 64'd1);

    // 4: register 0 is never written, claims of r0 ignored
    drive_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive_alu(1'b0, '0, '0);
    check_eq("t4_alu_r0", 64'(bus_if.wr_en), 64'd0);
    drive_lsu(1'b1, 5'd0, 32'hCAFE);
    step(acc);
    check_eq("t4_lsu_r0_accepted", 64'(acc), 64'd1);
    drive_lsu(1'b0, '0, '0);
    tick();
    check_eq("t4_lsu_r0_no_wr", 64'(bus_if.wr_en), 64'd0);
    chk_adrs_a     = 5'd0;
    iss_claim      = 1'b1;
    iss_claim_adrs = 5'd0;
    tick();
    iss_claim = 1'b0;
    check_eq("t4_busy_r0", 64'(busy_a), 64'd0);
    check_eq("t4_idle", 64'(idle), 64'd1);

    // 5: double claim -> sticky error; reset mid-fill clears everything
    chk_adrs_b     = 5'd9;
    iss_claim      = 1'b1;
    iss_claim_adrs = 5'd9;
    tick();
    check_eq("t5_first_claim_ok", 64'(sb_err), 64'd0);
    tick();
    iss_claim = 1'b0;
    check_eq("t5_sb_err", 64'(sb_err), 64'd1);
    check_eq("t5_busy_b", 64'(busy_b), 64'd1);
    tick();
    check_eq("t5_sb_err_held", 64'(sb_err), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 5'd20, 32'(32'hB000 + i));
      drive_lsu(1'b1, 5'(11 + i), $urandom());
      tick();
    end
    drive_idle();
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    m_fifo.delete();
    #1;
    check_eq("t5_rst_ready",  64'(bus_if.lsu_ready), 64'd1);
    check_eq("t5_rst_sb_err", 64'(sb_err),           64'd0);
    check_eq("t5_rst_wr_en",  64'(bus_if.wr_en),     64'd0);
    check_eq("t5_rst_busy_b", 64'(busy_b),           64'd0);
    check_eq("t5_rst_idle",   64'(idle),             64'd1);
    @(posedge clk_cpu);
    #1;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check_eq("t5_post_rst_idle", 64'(idle), 64'd1);

`ifdef REGFILE_WB_BYPASS_EN
    // 6: forwarding of the pending r3 while it sits on the write port
    chk_adrs_a     = 5'd3;
    iss_claim      = 1'b1;
    iss_claim_adrs = 5'd3;
    tick();
    iss_claim = 1'b0;
    drive_lsu(1'b1, 5'd3, 32'h3333);
    tick();
    drive_lsu(1'b0, '0, '0);
    check_eq("t6_busy_before", 64'(busy_a), 64'd1);
    check_eq("t6_no_hit_before", 64'(fwd_hit_a), 64'd0);
    tick();
    check_eq("t6_fwd_hit_a", 64'(fwd_hit_a), 64'd1);
    check_eq("t6_busy_masked", 64'(busy_a), 64'd0);
    check_eq("t6_fwd_data", 64'(fwd_data), 64'h3333);
    tick();
    check_eq("t6_hit_gone", 64'(fwd_hit_a), 64'd0);
    check_eq("t6_busy_after", 64'(busy_a), 64'd0);
`endif

    // Random traffic; an unaccepted LSU offer is held until it transfers.
    drive_idle();
    for (int n = 0; n < 200; n++) begin
      drive_alu(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom());
      step(acc);
      if (!bus_if.lsu_valid || acc)
        drive_lsu(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom());
    end
    drive_idle();
    repeat (8) tick();
    check_eq("final_exp_empty", 64'(exp_q.size()), 64'd0);
    check_eq("final_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
